// File: rtl/bus_pkg.sv
// Shared types and constants for the bus arbiter: FSM encoding, channel index
// and burst counter widths, and active-low strobe helpers.
package bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_HOLD  = 2'd2
    } arb_state_e;

    // Wide enough for the largest channel count (8) and burst length (15).
    localparam int CHAN_IDX_W = 3;
    localparam int CNT_W      = 4;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    function automatic logic strobe_n(input logic active);
        return active ? STROBE_ON : STROBE_OFF;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first set bit of req_i at or
// after ptr_i, wrapping modulo N.
module rr_pick
    import bus_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]          req_i,
    input  logic [CHAN_IDX_W-1:0] ptr_i,
    output logic [CHAN_IDX_W-1:0] grant_o,
    output logic                  valid_o
);

    localparam logic [CHAN_IDX_W:0] N_W = (CHAN_IDX_W+1)'(N);

    logic [2*N-1:0]        req_dbl;
    logic [N-1:0]          req_rot;
    logic [CHAN_IDX_W-1:0] grant_chain [N+1];

    // Rotate so that bit 0 of req_rot is the channel at ptr_i.
    assign req_dbl = {req_i, req_i};
    assign req_rot = N'(req_dbl >> ptr_i);

    assign grant_chain[N] = '0;

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [CHAN_IDX_W:0]   sum;
        logic [CHAN_IDX_W-1:0] cand;
        assign sum  = {1'b0, ptr_i} + (CHAN_IDX_W+1)'(gi);
        assign cand = (sum >= N_W) ? CHAN_IDX_W'(sum - N_W) : CHAN_IDX_W'(sum);
        assign grant_chain[gi] = req_rot[gi] ? cand : grant_chain[gi+1];
    end

    assign grant_o = grant_chain[0];
    assign valid_o = |req_i;

endmodule

// File: rtl/bus_arbiter.sv
// Memory-bus arbiter between the CPU and NUM_DMA DMA channels, with RAM port mux.
// Optional macro BUS_ARB_FIXED_PRIO_EN: lowest-index requester always wins.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_DMA   = 2,
    parameter int BURST_LEN = 4,
    parameter int DMA_AW    = 18,
    parameter int RAM_AW    = 16,
    parameter int DW        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_arbitrate,
    input  logic [21:0]               cpu_addr,
    input  logic [DW-1:0]             cpu_data_in,
    input  logic                      cpu_rd,
    input  logic                      cpu_wr,
    input  logic                      cpu_byte_op,
    input  logic                      cpu_ram_access,
    output logic                      bus_ack,
    input  logic [NUM_DMA-1:0]        dma_req,
    output logic [NUM_DMA-1:0]        dma_ack,
    input  logic [NUM_DMA*DMA_AW-1:0] dma_addr,
    input  logic [NUM_DMA*DW-1:0]     dma_data_in,
    input  logic [NUM_DMA-1:0]        dma_rd,
    input  logic [NUM_DMA-1:0]        dma_wr,
    output logic [RAM_AW-1:0]         ram_addr,
    output logic [DW-1:0]             ram_data_in,
    output logic                      ram_byte_op,
    output logic                      ram_ce_n,
    output logic                      ram_we_n,
    output logic                      ram_oe_n,
    output logic [2:0]                cur_chan
);

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

    arb_state_e            state_q, state_d;
    logic [CHAN_IDX_W-1:0] cur_chan_q, cur_chan_d;
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;

    logic [NUM_DMA-1:0]    chan_sel;
    logic                  in_burst;
    logic                  req_cur;
    logic                  burst_end;
    logic [CHAN_IDX_W-1:0] pick_idx;
    logic                  pick_valid;

    logic [RAM_AW-1:0]     addr_chain [NUM_DMA+1];
    logic [DW-1:0]         data_chain [NUM_DMA+1];
    logic [NUM_DMA:0]      rd_chain;
    logic [NUM_DMA:0]      wr_chain;

    logic                  unused_ok;

    assign addr_chain[NUM_DMA] = '0;
    assign data_chain[NUM_DMA] = '0;
    assign rd_chain[NUM_DMA]   = 1'b0;
    assign wr_chain[NUM_DMA]   = 1'b0;

    // chan_sel is one-hot, so a priority chain acts as a plain mux.
    for (genvar gi = 0; gi < NUM_DMA; gi++) begin : g_chan
        assign chan_sel[gi]   = (cur_chan_q == CHAN_IDX_W'(gi));
        assign addr_chain[gi] = chan_sel[gi] ? dma_addr[gi*DMA_AW +: RAM_AW] : addr_chain[gi+1];
        assign data_chain[gi] = chan_sel[gi] ? dma_data_in[gi*DW +: DW] : data_chain[gi+1];
        assign rd_chain[gi]   = chan_sel[gi] ? dma_rd[gi] : rd_chain[gi+1];
        assign wr_chain[gi]   = chan_sel[gi] ? dma_wr[gi] : wr_chain[gi+1];
    end

    assign in_burst  = (state_q == ARB_BURST);
    assign req_cur   = |(dma_req & chan_sel);
    assign burst_end = in_burst && (!req_cur || burst_cnt_q == BURST_MAX);

`ifdef BUS_ARB_FIXED_PRIO_EN
    logic [CHAN_IDX_W-1:0] fp_chain [NUM_DMA+1];

    assign fp_chain[NUM_DMA] = '0;
    for (genvar gi = 0; gi < NUM_DMA; gi++) begin : g_fixed
        assign fp_chain[gi] = dma_req[gi] ? CHAN_IDX_W'(gi) : fp_chain[gi+1];
    end

    assign pick_idx   = fp_chain[0];
    assign pick_valid = |dma_req;
`else
    localparam logic [CHAN_IDX_W-1:0] LAST_CHAN = CHAN_IDX_W'(NUM_DMA - 1);

    logic [CHAN_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CHAN_IDX_W-1:0] next_chan;

    assign next_chan = (cur_chan_q == LAST_CHAN) ? '0 : cur_chan_q + 1'b1;

    // The channel just served drops to lowest priority for the next pick.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (burst_end) begin
            rr_ptr_d = next_chan;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    rr_pick #(
        .N (NUM_DMA)
    ) u_rr_pick (
        .req_i   (dma_req),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_idx),
        .valid_o (pick_valid)
    );
`endif

    always_comb begin
        state_d     = state_q;
        cur_chan_d  = cur_chan_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (bus_arbitrate && pick_valid) begin
                    state_d     = ARB_BURST;
                    cur_chan_d  = pick_idx;
                    burst_cnt_d = CNT_W'(1);
                end
            end
            ARB_BURST: begin
                if (burst_end) begin
                    state_d = ARB_HOLD;
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            // One guaranteed CPU cycle between bursts.
            ARB_HOLD: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            cur_chan_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_chan_q  <= cur_chan_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign bus_ack  = ~in_burst;
    assign dma_ack  = in_burst ? chan_sel : '0;
    assign cur_chan = cur_chan_q;

    // A channel asserting both strobes is treated as a write.
    always_comb begin
        ram_addr    = cpu_addr[RAM_AW-1:0];
        ram_data_in = cpu_data_in;
        ram_byte_op = cpu_byte_op;
        ram_ce_n    = strobe_n((cpu_rd | cpu_wr) & cpu_ram_access);
        ram_we_n    = strobe_n(cpu_wr & cpu_ram_access);
        ram_oe_n    = strobe_n(cpu_rd & cpu_ram_access);
        if (in_burst) begin
            ram_addr    = addr_chain[0];
            ram_data_in = data_chain[0];
            ram_byte_op = 1'b0;
            ram_ce_n    = strobe_n(rd_chain[0] | wr_chain[0]);
            ram_we_n    = strobe_n(wr_chain[0]);
            ram_oe_n    = strobe_n(rd_chain[0] & ~wr_chain[0]);
        end
    end

    // Upper address bits do not reach the RAM.
    assign unused_ok = ^{cpu_addr, dma_addr};

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised scoreboard bench for bus_arbiter: the stimulus process pushes the
// expected outputs of each cycle, and a negedge monitor pops and compares them.
module tb_bus_arbiter;

    localparam int NUM_DMA   = 2;
    localparam int BURST_LEN = 4;
    localparam int DMA_AW    = 18;
    localparam int RAM_AW    = 16;
    localparam int DW        = 16;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      bus_arbitrate;
    logic [21:0]               cpu_addr;
    logic [DW-1:0]             cpu_data_in;
    logic                      cpu_rd, cpu_wr, cpu_byte_op, cpu_ram_access;
    logic                      bus_ack;
    logic [NUM_DMA-1:0]        dma_req;
    logic [NUM_DMA-1:0]        dma_ack;
    logic [NUM_DMA*DMA_AW-1:0] dma_addr;
    logic [NUM_DMA*DW-1:0]     dma_data_in;
    logic [NUM_DMA-1:0]        dma_rd, dma_wr;
    logic [RAM_AW-1:0]         ram_addr;
    logic [DW-1:0]             ram_data_in;
    logic                      ram_byte_op, ram_ce_n, ram_we_n, ram_oe_n;
    logic [2:0]                cur_chan;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_DMA(NUM_DMA), .BURST_LEN(BURST_LEN), .DMA_AW(DMA_AW),
        .RAM_AW(RAM_AW), .DW(DW)
    ) dut (
        .clk(clk), .reset(reset), .bus_arbitrate(bus_arbitrate),
        .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_rd(cpu_rd),
        .cpu_wr(cpu_wr), .cpu_byte_op(cpu_byte_op), .cpu_ram_access(cpu_ram_access),
        .bus_ack(bus_ack), .dma_req(dma_req), .dma_ack(dma_ack),
        .dma_addr(dma_addr), .dma_data_in(dma_data_in), .dma_rd(dma_rd),
        .dma_wr(dma_wr), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_byte_op(ram_byte_op), .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n),
        .ram_oe_n(ram_oe_n), .cur_chan(cur_chan)
    );

    typedef struct {
        logic               bus_ack;
        logic [NUM_DMA-1:0] dma_ack;
        int                 owner;
        logic [RAM_AW-1:0]  addr;
        logic [DW-1:0]      data;
        logic               byte_op, ce_n, we_n, oe_n;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model: who owns the bus, how many cycles it has had,
    // whether the CPU is owed its guaranteed cycle, and where the search starts.
    int   m_owner = -1;
    int   m_used  = 0;
    bit   m_owed  = 1'b0;
    int   m_start = 0;

    function automatic int first_req(input logic [NUM_DMA-1:0] req, input int start);
        for (int k = 0; k < NUM_DMA; k++) begin
            int idx;
            idx = (start + k) % NUM_DMA;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    // Advance the model across one rising edge using the inputs held this cycle.
    task automatic model_clock();
        if (reset) begin
            m_owner = -1; m_used = 0; m_owed = 1'b0; m_start = 0;
        end else if (m_owner >= 0) begin
            if (!dma_req[m_owner] || m_used == BURST_LEN) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
                m_start = 0;
`else
                m_start = (m_owner + 1) % NUM_DMA;
`endif
                m_owner = -1;
                m_owed  = 1'b1;
            end else begin
                m_used++;
            end
        end else if (m_owed) begin
            m_owed = 1'b0;
        end else if (bus_arbitrate && dma_req != '0) begin
            m_owner = first_req(dma_req, m_start);
            m_used  = 1;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.owner   = m_owner;
        e.bus_ack = (m_owner < 0);
        e.dma_ack = (m_owner < 0) ? '0 : (NUM_DMA'(1) << m_owner);
        if (m_owner < 0) begin
            e.addr    = cpu_addr[RAM_AW-1:0];
            e.data    = cpu_data_in;
            e.byte_op = cpu_byte_op;
            e.ce_n    = !((cpu_rd || cpu_wr) && cpu_ram_access);
            e.we_n    = !(cpu_wr && cpu_ram_access);
            e.oe_n    = !(cpu_rd && cpu_ram_access);
        end else begin
            e.addr    = dma_addr[m_owner*DMA_AW +: RAM_AW];
            e.data    = dma_data_in[m_owner*DW +: DW];
            e.byte_op = 1'b0;
            e.ce_n    = !(dma_rd[m_owner] || dma_wr[m_owner]);
            e.we_n    = !dma_wr[m_owner];
            e.oe_n    = !(dma_rd[m_owner] && !dma_wr[m_owner]);
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_clock();
    endtask

    task automatic randomize_data(input bit cpu_active);
        cpu_addr       = 22'($urandom);
        cpu_data_in    = DW'($urandom);
        cpu_byte_op    = 1'($urandom);
        cpu_rd         = cpu_active ? 1'($urandom) : 1'b0;
        cpu_wr         = cpu_active ? 1'($urandom) : 1'b0;
        cpu_ram_access = 1'($urandom);
        for (int i = 0; i < NUM_DMA; i++) begin
            dma_addr[i*DMA_AW +: DMA_AW] = DMA_AW'($urandom);
            dma_data_in[i*DW +: DW]      = DW'($urandom);
        end
        dma_rd = NUM_DMA'($urandom);
        dma_wr = NUM_DMA'($urandom);
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (bus_ack !== mon_e.bus_ack || dma_ack !== mon_e.dma_ack ||
                (mon_e.owner >= 0 && cur_chan !== 3'(mon_e.owner))) begin
                errors++;
                $display("FAIL grant cyc=%0d: got bus_ack=%b dma_ack=%b cur_chan=%0d, want bus_ack=%b dma_ack=%b owner=%0d",
                         cyc, bus_ack, dma_ack, cur_chan, mon_e.bus_ack, mon_e.dma_ack, mon_e.owner);
            end
            checks++;
            if (ram_addr !== mon_e.addr || ram_data_in !== mon_e.data ||
                ram_byte_op !== mon_e.byte_op || ram_ce_n !== mon_e.ce_n ||
                ram_we_n !== mon_e.we_n || ram_oe_n !== mon_e.oe_n) begin
                errors++;
                $display("FAIL ram_port cyc=%0d: got addr=%o data=%o byte=%b ce_n=%b we_n=%b oe_n=%b, want addr=%o data=%o byte=%b ce_n=%b we_n=%b oe_n=%b",
                         cyc, ram_addr, ram_data_in, ram_byte_op, ram_ce_n, ram_we_n, ram_oe_n,
                         mon_e.addr, mon_e.data, mon_e.byte_op, mon_e.ce_n, mon_e.we_n, mon_e.oe_n);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset = 1'b1; bus_arbitrate = 1'b0; dma_req = '0;
        cpu_addr = '0; cpu_data_in = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        cpu_byte_op = 1'b0; cpu_ram_access = 1'b0;
        dma_addr = '0; dma_data_in = '0; dma_rd = '0; dma_wr = '0;

        repeat (3) begin
            tick(); push_expect();
        end

        // Single requester, full bursts, then reset in the middle of a burst.
        for (int i = 0; i < 17; i++) begin
            tick();
            reset = (i == 16); bus_arbitrate = 1'b1; dma_req = 2'b01;
            randomize_data(i != 16);
            push_expect();
        end

        // Both channels requesting continuously.
        for (int i = 0; i < 24; i++) begin
            tick();
            reset = 1'b0; bus_arbitrate = 1'b1; dma_req = 2'b11;
            randomize_data(1'b1);
            push_expect();
        end

        // Channel 1 releases after two granted cycles.
        guard = 0;
        do begin
            tick();
            dma_req = (m_owner == 1 && m_used == 2) ? 2'b01 : 2'b11;
            randomize_data(1'b1);
            push_expect();
            guard++;
        end while (!(m_owner == 1 && m_used == 2) && guard < 40);
        if (guard >= 40) begin
            errors++;
            $display("FAIL early_release: no chan1 grant within 40 cycles, want one");
        end
        for (int i = 0; i < 6; i++) begin
            tick(); dma_req = 2'b01; randomize_data(1'b1); push_expect();
        end

        // Arbitration gated off while the CPU reads RAM.
        for (int i = 0; i < 16; i++) begin
            tick();
            bus_arbitrate = 1'b0; dma_req = 2'b01;
            randomize_data(1'b1);
            cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_ram_access = 1'b1; cpu_addr = 22'o001000;
            push_expect();
        end

        // Channel 1 asserts read and write together.
        for (int i = 0; i < 12; i++) begin
            tick();
            bus_arbitrate = 1'b1; dma_req = 2'b10;
            randomize_data(1'b1);
            dma_rd = 2'b11; dma_wr = 2'b11;
            dma_addr[DMA_AW +: DMA_AW] = 18'o040000;
            dma_data_in[DW +: DW] = 16'o123456;
            push_expect();
        end

        // Random traffic with sticky requests and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset = ($urandom_range(199) == 0);
            bus_arbitrate = ($urandom_range(7) != 0);
            for (int c = 0; c < NUM_DMA; c++) begin
                if ($urandom_range(7) == 0) dma_req[c] = ~dma_req[c];
            end
            randomize_data(!reset);
            push_expect();
        end

        tick();
        reset = 1'b0;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Parametrised memory-bus arbiter with a RAM port mux. It sits between the CPU bus interface, NUM_DMA device DMA channels, and the RAM.
- CPU owns RAM by default.
- DMA channels win bursts of up to BURST_LEN cycles, served round-robin, only while the CPU signals a safe point.
- Replaces the single-channel, fixed 4-cycle grant logic.

Parameters:
NUM_DMA, 2, number of DMA channels (1..8)
BURST_LEN, 4, maximum DMA cycles per grant (1..15)
DMA_AW, 18, DMA address width; RAM uses low RAM_AW bits
RAM_AW, 16, RAM address width
DW, 16, data width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
bus_arbitrate  in  1  CPU at safe point; DMA may be granted
cpu_addr  in  22  CPU bus address
cpu_data_in  in  DW  CPU write data
cpu_rd, cpu_wr, cpu_byte_op  in  1 each  CPU strobes
cpu_ram_access  in  1  CPU address decodes to RAM
bus_ack  out  1  CPU owns bus
dma_req  in  NUM_DMA  per-channel request
dma_ack  out  NUM_DMA  one-hot grant
dma_addr  in  NUM_DMA*DMA_AW  packed, channel i at [i*DMA_AW +: DMA_AW]
dma_data_in  in  NUM_DMA*DW  packed write data
dma_rd, dma_wr  in  NUM_DMA  per-channel strobes
ram_addr  out  RAM_AW  muxed address
ram_data_in  out  DW  muxed write data
ram_byte_op  out  1  byte op (CPU only; 0 during DMA)
ram_ce_n, ram_we_n, ram_oe_n  out  1 each  active-low RAM controls
cur_chan  out  3  granted channel index (valid when bus_ack=0)

Behaviour:
- States: IDLE (CPU owns), BURST (DMA owns), HOLD (forced CPU cycle).
- IDLE -> BURST when bus_arbitrate=1 and any dma_req set.
  - Selected channel = first requester at or after rr_ptr, modulo NUM_DMA.
  - Register it as cur_chan; load burst_cnt=1.
- BURST, each cycle:
  - If dma_req[cur_chan]=0 -> HOLD (early release).
  - Else if burst_cnt==BURST_LEN -> HOLD.
  - Else burst_cnt++.
- HOLD -> IDLE unconditionally after one cycle. The CPU is guaranteed at least one owned cycle between bursts, so a continuous requester cannot starve the CPU.
- rr_ptr <= cur_chan+1 (wrap to 0 at NUM_DMA) on entering HOLD. The channel just served gets lowest priority next time.
- Grant outputs:
  - bus_ack = 1 in IDLE and HOLD.
  - dma_ack = one-hot(cur_chan) in BURST only, zero otherwise.
  - Both are registered-state decodes; they change the cycle after the decision.
- RAM controls when the CPU owns the bus:
  - ce_n = ~((cpu_rd|cpu_wr) & cpu_ram_access)
  - we_n = ~(cpu_wr & cpu_ram_access)
  - oe_n = ~(cpu_rd & cpu_ram_access)
  - addr = cpu_addr[RAM_AW-1:0]
- RAM controls during BURST: take the selected channel's strobes, address and data; byte_op=0.
- If dma_rd and dma_wr are both asserted on the granted channel, the write wins: we_n=0, oe_n=1.
- Requests arriving while bus_arbitrate=0 are held off; no grant is ever given without bus_arbitrate in IDLE. bus_arbitrate is ignored in BURST and HOLD.
- Reset (any state, including mid-burst), next edge:
  - state=IDLE, rr_ptr=0, burst_cnt=0, cur_chan=0.
  - bus_ack=1, dma_ack=0.
  - RAM strobes follow CPU inputs, which are inactive during reset → ce_n=we_n=oe_n=1.
- NUM_DMA=1: round-robin degenerates to a single channel; rr_ptr stays 0.

Optional Feature:
BUS_ARB_FIXED_PRIO_EN
- Defined: round-robin is disabled. The lowest-index requesting channel always wins, rr_ptr is not implemented, and the HOLD cycle is still enforced.
- Undefined: round-robin as above.

Decomposition:
- Package bus_pkg: state encoding (ARB_IDLE, ARB_BURST, ARB_HOLD), channel-index width constant, active-low strobe helper constants.
- One sub-module, rr_pick: combinational round-robin selector. Inputs: req vector, ptr. Outputs: grant index, valid. Instantiated once; bypassed under BUS_ARB_FIXED_PRIO_EN.

Test Plan:
- Reset mid-burst: chan0 in BURST, assert reset 1 cycle -> next cycle bus_ack=1, dma_ack=00, ram_ce_n=1.
- Single full burst: dma_req=01 held, bus_arbitrate=1 -> dma_ack=01 for exactly 4 cycles, then bus_ack=1 for ≥1 cycle, then re-grant.
- Round-robin: dma_req=11 continuous -> grant sequence chan0, chan1, chan0, each 4 cycles with one HOLD cycle between. With FIXED_PRIO_EN: chan0 every time.
- Early release: chan1 drops dma_req after 2 granted cycles -> HOLD next cycle, rr_ptr=0.
- Gating: dma_req=01, bus_arbitrate=0 for 10 cycles -> dma_ack stays 0, CPU cpu_rd to RAM address 0o001000 gives ram_addr=0o001000, ram_oe_n=0.
- Mux/write priority: granted chan1 asserts dma_rd=dma_wr=1, dma_addr=0o040000, data 0o123456 -> ram_we_n=0, ram_oe_n=1, ram_addr=0o040000, ram_byte_op=0.
